// File: rtl/alu_secuencial.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_secuencial : registered, handshaked ALU with iterative one-bit-per-clock
// shifts and full status flags. Optional rotates under ALU_ROTACION_EN.
// Revision 1.0
// ---------------------------------------------------------------------------
module alu_secuencial #(
   parameter int ANCHO = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valido_i,
   output logic             listo_o,
   input  logic [ANCHO-1:0] ALUa_i,
   input  logic [ANCHO-1:0] ALUb_i,
   input  logic             ALUflagin_i,
   input  logic [3:0]       ALUcontrol_i,
   output logic [ANCHO-1:0] ALUresult_o,
   output logic             ALUflags_o,
   output logic             zero_o,
   output logic             negativo_o,
   output logic             desbordamiento_o,
   output logic             valido_o
);

   localparam int CW = $clog2(ANCHO + 2);
   localparam logic [CW-1:0] N_MAX = CW'(ANCHO + 1);

   localparam logic [3:0] OP_AND = 4'h0;
   localparam logic [3:0] OP_OR  = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_INC = 4'h3;
   localparam logic [3:0] OP_DEC = 4'h4;
   localparam logic [3:0] OP_NOT = 4'h5;
   localparam logic [3:0] OP_SUB = 4'h6;
   localparam logic [3:0] OP_XOR = 4'h7;
   localparam logic [3:0] OP_SHL = 4'h8;
   localparam logic [3:0] OP_SHR = 4'h9;
`ifdef ALU_ROTACION_EN
   localparam logic [3:0] OP_ROL = 4'hA;
   localparam logic [3:0] OP_ROR = 4'hB;
`endif

   typedef enum logic [0:0] {
      REPOSO   = 1'b0,
      DESPLAZA = 1'b1
   } state_t;

   state_t           state, state_n;
   logic [ANCHO-1:0] work, work_n;
   logic [CW-1:0]    count, count_n;
   logic             fill, fill_n;
   logic             dir_left, dir_left_n;
   logic             rot_mode, rot_mode_n;

   logic [ANCHO-1:0] res_n;
   logic             flag_n, zero_n, neg_n, ovf_n, vld_n;
   logic             wr;

   logic [ANCHO:0]   sum, diff;
   logic [ANCHO-1:0] sel;
   logic [CW-1:0]    shift_n;
   logic             out_bit, in_bit;
   logic [ANCHO-1:0] shifted;

   assign listo_o = (state == REPOSO) && !rst_i;

   assign sum  = {1'b0, ALUa_i} + {1'b0, ALUb_i} + {{ANCHO{1'b0}}, ALUflagin_i};
   assign diff = {1'b0, ALUa_i} - {1'b0, ALUb_i} - {{ANCHO{1'b0}}, ALUflagin_i};
   assign sel  = ALUflagin_i ? ALUb_i : ALUa_i;

   // Capping at ANCHO+1 flushes every original bit plus one fill bit out.
   assign shift_n = (ALUb_i > ANCHO'(ANCHO + 1)) ? N_MAX : CW'(ALUb_i);

   always_comb begin
      out_bit = dir_left ? work[ANCHO-1] : work[0];
      in_bit  = rot_mode ? out_bit : fill;
      shifted = dir_left ? {work[ANCHO-2:0], in_bit} : {in_bit, work[ANCHO-1:1]};
   end

   always_comb begin
      state_n    = state;
      work_n     = work;
      count_n    = count;
      fill_n     = fill;
      dir_left_n = dir_left;
      rot_mode_n = rot_mode;
      res_n      = ALUresult_o;
      flag_n     = ALUflags_o;
      ovf_n      = desbordamiento_o;
      wr         = 1'b0;

      case (state)
         REPOSO: begin
            if (valido_i) begin
               wr     = 1'b1;
               flag_n = 1'b0;
               ovf_n  = 1'b0;
               case (ALUcontrol_i)
                  OP_AND: res_n = ALUa_i & ALUb_i;
                  OP_OR:  res_n = ALUa_i | ALUb_i;
                  OP_XOR: res_n = ALUa_i ^ ALUb_i;
                  OP_ADD: begin
                     res_n  = sum[ANCHO-1:0];
                     flag_n = sum[ANCHO];
                     ovf_n  = (ALUa_i[ANCHO-1] == ALUb_i[ANCHO-1]) &&
                              (sum[ANCHO-1] != ALUa_i[ANCHO-1]);
                  end
                  OP_SUB: begin
                     res_n  = diff[ANCHO-1:0];
                     flag_n = diff[ANCHO];
                     ovf_n  = (ALUa_i[ANCHO-1] != ALUb_i[ANCHO-1]) &&
                              (diff[ANCHO-1] != ALUa_i[ANCHO-1]);
                  end
                  OP_INC: res_n = sel + ANCHO'(1);
                  OP_DEC: res_n = sel - ANCHO'(1);
                  OP_NOT: res_n = ~sel;
                  OP_SHL, OP_SHR: begin
                     if (shift_n == '0) begin
                        res_n = ALUa_i;
                     end else begin
                        wr         = 1'b0;
                        work_n     = ALUa_i;
                        count_n    = shift_n;
                        fill_n     = ALUflagin_i;
                        dir_left_n = (ALUcontrol_i == OP_SHL);
                        rot_mode_n = 1'b0;
                        state_n    = DESPLAZA;
                     end
                  end
`ifdef ALU_ROTACION_EN
                  OP_ROL, OP_ROR: begin
                     if ((ALUb_i % ANCHO'(ANCHO)) == '0) begin
                        res_n = ALUa_i;
                     end else begin
                        wr         = 1'b0;
                        work_n     = ALUa_i;
                        count_n    = CW'(ALUb_i % ANCHO'(ANCHO));
                        fill_n     = 1'b0;
                        dir_left_n = (ALUcontrol_i == OP_ROL);
                        rot_mode_n = 1'b1;
                        state_n    = DESPLAZA;
                     end
                  end
`endif
                  default: res_n = '0;
               endcase
            end
         end
         DESPLAZA: begin
            work_n  = shifted;
            count_n = count - CW'(1);
            if (count == CW'(1)) begin
               wr      = 1'b1;
               res_n   = shifted;
               flag_n  = out_bit;
               ovf_n   = 1'b0;
               state_n = REPOSO;
            end
         end
         default: state_n = REPOSO;
      endcase

      vld_n  = wr;
      zero_n = wr ? (res_n == '0) : zero_o;
      neg_n  = wr ? res_n[ANCHO-1] : negativo_o;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= REPOSO;
      end else begin
         state <= state_n;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         work             <= '0;
         count            <= '0;
         fill             <= 1'b0;
         dir_left         <= 1'b0;
         rot_mode         <= 1'b0;
         ALUresult_o      <= '0;
         ALUflags_o       <= 1'b0;
         zero_o           <= 1'b0;
         negativo_o       <= 1'b0;
         desbordamiento_o <= 1'b0;
         valido_o         <= 1'b0;
      end else begin
         work             <= work_n;
         count            <= count_n;
         fill             <= fill_n;
         dir_left         <= dir_left_n;
         rot_mode         <= rot_mode_n;
         ALUresult_o      <= res_n;
         ALUflags_o       <= flag_n;
         zero_o           <= zero_n;
         negativo_o       <= neg_n;
         desbordamiento_o <= ovf_n;
         valido_o         <= vld_n;
      end
   end

endmodule
`default_nettype wire
